// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared encodings for the simple RISC CPU control path: FSM states,
// instruction field values, datapath select encodings and the strobe bundle.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDPC,
        S_DEC,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WB,
        S_WIMM,
        S_HALT
    } state_t;

    // opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // op field IR[12:11]
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] REG_RN = 2'b00;
    localparam logic [1:0] REG_RD = 2'b01;
    localparam logic [1:0] REG_RM = 2'b10;

    localparam logic [1:0] VSEL_C      = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    typedef struct packed {
        logic       reset_pc;
        logic       load_pc;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       load_ir;
        logic [1:0] reg_sel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic [1:0] alu_op;
        logic       waiting;
        logic       halted;
    } ctrl_t;

    // CMP is the only ALU instruction without a write-back cycle
    function automatic logic is_cmp(input logic [2:0] opcode, input logic [1:0] op);
        return (opcode == OPC_ALU) && (op == OP_CMP);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Bundle between the control FSM and the CPU datapath: decoded IR fields in,
// every load/select strobe plus status flags and the retired count out.
interface cpu_ctrl_if #(parameter int CNT_W = 16);

    logic [2:0]       opcode;
    logic [1:0]       op;
    logic             reset_pc;
    logic             load_pc;
    logic             addr_sel;
    logic [1:0]       mem_cmd;
    logic             load_ir;
    logic [1:0]       reg_sel;
    logic [1:0]       vsel;
    logic             write;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             asel;
    logic [1:0]       alu_op;
    logic             waiting;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport ctrl (
        input  opcode, op,
        output reset_pc, load_pc, addr_sel, mem_cmd, load_ir, reg_sel, vsel,
               write, loada, loadb, loadc, loads, asel, alu_op,
               waiting, halted, retired
    );

    modport dp (
        output opcode, op,
        input  reset_pc, load_pc, addr_sel, mem_cmd, load_ir, reg_sel, vsel,
               write, loada, loadb, loadc, loads, asel, alu_op,
               waiting, halted, retired
    );

endinterface

// File: rtl/cpu_ctrl_fsm_outdec.sv
// Moore output decoder: maps the current state to the strobe bundle. Only the
// execute state looks at the instruction fields, to pick ALU operation and
// which result register to load.
import cpu_ctrl_pkg::*;

module cpu_ctrl_outdec (
    input  state_t     state_i,
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    output ctrl_t      ctrl_o
);

    // Every strobe defaults low and every select to zero; states only raise what they use
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_RST: begin
                ctrl_o.reset_pc = 1'b1;
                ctrl_o.load_pc  = 1'b1;
            end
            S_IF1: begin
                ctrl_o.addr_sel = 1'b1;
                ctrl_o.mem_cmd  = MEM_READ;
                ctrl_o.waiting  = 1'b1;
            end
            S_IF2: begin
                ctrl_o.addr_sel = 1'b1;
                ctrl_o.mem_cmd  = MEM_READ;
                ctrl_o.load_ir  = 1'b1;
            end
            S_UPDPC: begin
                ctrl_o.load_pc = 1'b1;
            end
            S_GETA: begin
                ctrl_o.reg_sel = REG_RN;
                ctrl_o.loada   = 1'b1;
            end
            S_GETB: begin
                ctrl_o.reg_sel = REG_RM;
                ctrl_o.loadb   = 1'b1;
            end
            S_EXEC: begin
                if (opcode_i == OPC_MOV) begin
                    // MOV reg passes Rm through the ALU as 0 + B
                    ctrl_o.asel   = 1'b1;
                    ctrl_o.alu_op = ALU_ADD;
                    ctrl_o.loadc  = 1'b1;
                end else begin
                    ctrl_o.alu_op = op_i;
                    ctrl_o.asel   = (op_i == OP_MVN);
                    if (op_i == OP_CMP) begin
                        ctrl_o.loads = 1'b1;
                    end else begin
                        ctrl_o.loadc = 1'b1;
                    end
                end
            end
            S_WB: begin
                ctrl_o.reg_sel = REG_RD;
                ctrl_o.vsel    = VSEL_C;
                ctrl_o.write   = 1'b1;
            end
            S_WIMM: begin
                ctrl_o.reg_sel = REG_RN;
                ctrl_o.vsel    = VSEL_SXIMM8;
                ctrl_o.write   = 1'b1;
            end
            S_HALT: begin
                ctrl_o.waiting = 1'b1;
                ctrl_o.halted  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Main control FSM of the 16-bit RISC CPU: state register, next-state decode
// and the retired-instruction counter. Strobes come from cpu_ctrl_outdec.
import cpu_ctrl_pkg::*;

module cpu_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    cpu_ctrl_if.ctrl   bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    ctrl_t            ctrl;

    // Next-state decode; IR fields are only consulted in decode and execute
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_IF1;
            S_IF1:   state_d = S_IF2;
            S_IF2:   state_d = S_UPDPC;
            S_UPDPC: state_d = S_DEC;
            S_DEC: begin
                if (bus.opcode == OPC_MOV && bus.op == OP_MOV_IMM) begin
                    state_d = S_WIMM;
                end else if (bus.opcode == OPC_MOV && bus.op == OP_MOV_REG) begin
                    state_d = S_GETB;
                end else if (bus.opcode == OPC_ALU && bus.op == OP_MVN) begin
                    state_d = S_GETB;
                end else if (bus.opcode == OPC_ALU) begin
                    state_d = S_GETA;
                end else if (bus.opcode == OPC_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_IF1;   // unsupported encoding retires as a NOP
                end
            end
            S_GETA:  state_d = S_GETB;
            S_GETB:  state_d = S_EXEC;
            S_EXEC:  state_d = is_cmp(bus.opcode, bus.op) ? S_IF1 : S_WB;
            S_WB:    state_d = S_IF1;
            S_WIMM:  state_d = S_IF1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // An instruction retires on the edge that finishes it: write-back, CMP
    // execute, NOP decode, or the step into halt
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_WB, S_WIMM: retire = 1'b1;
            S_EXEC:       retire = is_cmp(bus.opcode, bus.op);
            S_DEC:        retire = (state_d == S_IF1) || (state_d == S_HALT);
            default:      retire = 1'b0;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // State and counter registers; reset wins over any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RST;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    cpu_ctrl_outdec u_outdec (
        .state_i  (state_q),
        .opcode_i (bus.opcode),
        .op_i     (bus.op),
        .ctrl_o   (ctrl)
    );

    assign bus.reset_pc = ctrl.reset_pc;
    assign bus.load_pc  = ctrl.load_pc;
    assign bus.addr_sel = ctrl.addr_sel;
    assign bus.mem_cmd  = ctrl.mem_cmd;
    assign bus.load_ir  = ctrl.load_ir;
    assign bus.reg_sel  = ctrl.reg_sel;
    assign bus.vsel     = ctrl.vsel;
    assign bus.write    = ctrl.write;
    assign bus.loada    = ctrl.loada;
    assign bus.loadb    = ctrl.loadb;
    assign bus.loadc    = ctrl.loadc;
    assign bus.loads    = ctrl.loads;
    assign bus.asel     = ctrl.asel;
    assign bus.alu_op   = ctrl.alu_op;
    assign bus.waiting  = ctrl.waiting;
    assign bus.halted   = ctrl.halted;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: per-instruction vector table, random instruction
// stream against a cycle/retire model, halt, mid-instruction reset and
// counter wrap on a narrow second instance.
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst2;

    cpu_ctrl_if #(.CNT_W(16)) ifc ();
    cpu_ctrl_if #(.CNT_W(2))  ifc2 ();

    cpu_ctrl_fsm #(.CNT_W(16)) dut  (.clk(clk), .rst(rst),  .bus(ifc));
    cpu_ctrl_fsm #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst2), .bus(ifc2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic strobes_any();
        return ifc.reset_pc | ifc.load_pc | ifc.addr_sel | (|ifc.mem_cmd) | ifc.load_ir |
               ifc.write | ifc.loada | ifc.loadb | ifc.loadc | ifc.loads | ifc.asel;
    endfunction

    // Runs one instruction starting in the fetch-wait cycle and gathers what
    // the controller did until waiting rises again (bounded)
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] op,
                             output int n, output int w, output int la, output int lb,
                             output int lc, output int ls, output logic [1:0] alu,
                             output logic asl, output logic [1:0] wrs,
                             output logic [1:0] wvs, output logic [1:0] lbrs);
        ifc.opcode = opc;
        ifc.op     = op;
        n = 0; w = 0; la = 0; lb = 0; lc = 0; ls = 0;
        alu = 2'b00; asl = 1'b0; wrs = 2'b00; wvs = 2'b00; lbrs = 2'b00;
        do begin
            if (ifc.write) begin w++; wrs = ifc.reg_sel; wvs = ifc.vsel; end
            if (ifc.loada) la++;
            if (ifc.loadb) begin lb++; lbrs = ifc.reg_sel; end
            if (ifc.loadc) lc++;
            if (ifc.loads) ls++;
            if (ifc.loadc || ifc.loads) begin alu = ifc.alu_op; asl = ifc.asel; end
            step();
            n++;
        end while (!ifc.waiting && n < 40);
    endtask

    typedef struct {
        logic [2:0] opc;
        logic [1:0] op;
        string      name;
        int         period;
        int         w, la, lb, lc, ls;
        logic [1:0] alu;
        logic       asl;
        logic [1:0] wrs, wvs, lbrs;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n, w, la, lb, lc, ls;
        logic [1:0] alu, wrs, wvs, lbrs;
        logic asl;
        logic [15:0] r0;
        logic [15:0] mdl;
        logic bad;
        int wseen;

        tbl[0] = '{3'b110, 2'b10, "movimm", 5, 1, 0, 0, 0, 0, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00};
        tbl[1] = '{3'b110, 2'b00, "movreg", 7, 1, 0, 1, 1, 0, 2'b00, 1'b1, 2'b01, 2'b00, 2'b10};
        tbl[2] = '{3'b101, 2'b00, "add",    8, 1, 1, 1, 1, 0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10};
        tbl[3] = '{3'b101, 2'b01, "cmp",    7, 0, 1, 1, 0, 1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b10};
        tbl[4] = '{3'b101, 2'b10, "and",    8, 1, 1, 1, 1, 0, 2'b10, 1'b0, 2'b01, 2'b00, 2'b10};
        tbl[5] = '{3'b101, 2'b11, "mvn",    7, 1, 0, 1, 1, 0, 2'b11, 1'b1, 2'b01, 2'b00, 2'b10};
        tbl[6] = '{3'b000, 2'b00, "nop",    4, 0, 0, 0, 0, 0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};

        rst = 1'b1; rst2 = 1'b1;
        ifc.opcode = 3'b000; ifc.op = 2'b00;
        ifc2.opcode = 3'b110; ifc2.op = 2'b10;
        repeat (3) step();

        // reset state
        check("rst_reset_pc", ifc.reset_pc, 1);
        check("rst_load_pc", ifc.load_pc, 1);
        check("rst_retired", ifc.retired, 0);
        check("rst_halted", ifc.halted, 0);
        check("rst_waiting", ifc.waiting, 0);
        rst = 1'b0;
        check("c1_reset_pc", ifc.reset_pc, 1);
        step();
        check("c2_waiting", ifc.waiting, 1);
        check("c2_mem_cmd", ifc.mem_cmd, 2'b01);
        check("c2_addr_sel", ifc.addr_sel, 1);
        check("c2_reset_pc", ifc.reset_pc, 0);
        check("c2_retired", ifc.retired, 0);

        // one instruction of each class
        for (int i = 0; i < 7; i++) begin
            r0 = ifc.retired;
            run_instr(tbl[i].opc, tbl[i].op, n, w, la, lb, lc, ls, alu, asl, wrs, wvs, lbrs);
            check({tbl[i].name, "_period"}, n, tbl[i].period);
            check({tbl[i].name, "_writes"}, w, tbl[i].w);
            check({tbl[i].name, "_loada"}, la, tbl[i].la);
            check({tbl[i].name, "_loadb"}, lb, tbl[i].lb);
            check({tbl[i].name, "_loadc"}, lc, tbl[i].lc);
            check({tbl[i].name, "_loads"}, ls, tbl[i].ls);
            check({tbl[i].name, "_alu_op"}, alu, tbl[i].alu);
            check({tbl[i].name, "_asel"}, asl, tbl[i].asl);
            check({tbl[i].name, "_wr_regsel"}, wrs, tbl[i].wrs);
            check({tbl[i].name, "_wr_vsel"}, wvs, tbl[i].wvs);
            check({tbl[i].name, "_lb_regsel"}, lbrs, tbl[i].lbrs);
            check({tbl[i].name, "_retired"}, ifc.retired, r0 + 16'd1);
        end

        // random instruction stream vs. model: period = fetch/decode (4)
        // + register reads + execute + write-back
        mdl = ifc.retired;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            logic [1:0] rp;
            int ep, ew, reads;
            ro = 3'($urandom_range(0, 6));
            rp = 2'($urandom_range(0, 3));
            if (ro == 3'b110 && rp == 2'b10) begin
                ep = 5; ew = 1;
            end else if (ro == 3'b110 && rp == 2'b00) begin
                ep = 4 + 1 + 1 + 1; ew = 1;
            end else if (ro == 3'b101) begin
                reads = (rp == 2'b11) ? 1 : 2;
                ew = (rp == 2'b01) ? 0 : 1;
                ep = 4 + reads + 1 + ew;
            end else begin
                ep = 4; ew = 0;
            end
            mdl = mdl + 16'd1;
            run_instr(ro, rp, n, w, la, lb, lc, ls, alu, asl, wrs, wvs, lbrs);
            check("rnd_period", n, ep);
            check("rnd_writes", w, ew);
            check("rnd_retired", ifc.retired, mdl);
        end

        // halt: retires, then sits quiet until reset
        r0 = ifc.retired;
        run_instr(3'b111, 2'b01, n, w, la, lb, lc, ls, alu, asl, wrs, wvs, lbrs);
        check("halt_period", n, 4);
        check("halt_writes", w, 0);
        check("halt_halted", ifc.halted, 1);
        check("halt_retired", ifc.retired, r0 + 16'd1);
        r0 = ifc.retired;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!ifc.waiting || !ifc.halted || strobes_any() || ifc.retired != r0) bad = 1'b1;
            step();
        end
        check("halt_hold", bad, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst_reset_pc", ifc.reset_pc, 1);
        check("halt_rst_halted", ifc.halted, 0);
        check("halt_rst_retired", ifc.retired, 0);
        step();
        check("halt_rst_if1", ifc.waiting, 1);

        // reset during GETB of an ADD: no write-back, counter cleared
        run_instr(3'b110, 2'b10, n, w, la, lb, lc, ls, alu, asl, wrs, wvs, lbrs);
        check("pre_add_retired", ifc.retired, 1);
        ifc.opcode = 3'b101; ifc.op = 2'b00;
        wseen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ifc.write) wseen++;
            step();
        end
        check("getb_loadb", ifc.loadb, 1);
        check("getb_regsel", ifc.reg_sel, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (ifc.write) wseen++;
        check("midrst_reset_pc", ifc.reset_pc, 1);
        check("midrst_retired", ifc.retired, 0);
        step();
        if (ifc.write) wseen++;
        check("midrst_if1", ifc.waiting, 1);
        check("midrst_no_write", wseen, 0);

        // narrow counter wraps 3 -> 0 after four MOV imm
        rst2 = 1'b1;
        step();
        rst2 = 1'b0;
        check("wrap_start", ifc2.retired, 0);
        step();
        for (int k = 1; k <= 4; k++) begin
            repeat (5) step();
            check("wrap_retired", ifc2.retired, k % 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
